// File: rtl/fault_injector_pkg.sv
// rtl/fault_injector_pkg.sv - shared types and constants for the fault injector
package fault_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'b00,
    FLIP   = 2'b01,
    STUCK0 = 2'b10,
    STUCK1 = 2'b11
  } fault_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } inj_state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/fault_injector_if.sv
// rtl/fault_injector_if.sv - data stream through the fault injector
interface fault_injector_if;
  logic x_i;
  logic y_o;
  logic fault_o;

  modport master (output x_i, input y_o, input fault_o);
  modport slave  (input x_i, output y_o, output fault_o);
endinterface

// File: rtl/fault_injector_lfsr16.sv
// rtl/fault_injector_lfsr16.sv - 16-bit right-shifting Galois LFSR
module lfsr16
  import fault_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [15:0] q_o
);

  // An all-zero seed would lock the generator at zero forever.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) begin
      q_d = (q_q >> 1) ^ (q_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= SEED_EFF;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fault_injector.sv
// rtl/fault_injector.sv - registered data path with pseudo-random flip / stuck-at injection
module fault_injector
  import fault_pkg::*;
#(
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          BURST_W = 4,
  parameter int          CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [1:0]         mode_i,
  input  logic [15:0]        thresh_i,
  input  logic [BURST_W-1:0] burst_len_i,
  input  logic               clr_i,
  fault_injector_if.slave    io,
  output logic [CNT_W-1:0]   fault_cnt_o
);

  localparam logic [BURST_W-1:0] REM_ONE = BURST_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

  logic [15:0]        lfsr;
  fault_mode_e        mode;
  logic               trigger;
  logic [BURST_W-1:0] rem_load;

  inj_state_e         state_q, state_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               stuck_q, stuck_d;
  logic               y_q, y_d;
  logic               fault_q, fault_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (en_i),
    .q_o   (lfsr)
  );

  assign mode     = fault_mode_e'(mode_i);
  assign trigger  = en_i && (mode != OFF) && (lfsr < thresh_i);
  // The triggering cycle is the first forced cycle, so rem counts the remainder.
  assign rem_load = (burst_len_i == '0) ? '0 : burst_len_i - REM_ONE;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stuck_d = stuck_q;
    y_d     = io.x_i;
    fault_d = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (trigger) begin
          fault_d = 1'b1;
          if (mode == FLIP) begin
            y_d = ~io.x_i;
          end else begin
            y_d     = mode_i[0];
            stuck_d = mode_i[0];
            rem_d   = rem_load;
            if (rem_load != '0) begin
              state_d = BURST;
            end
          end
        end
      end
      BURST: begin
        if (!en_i) begin
          state_d = IDLE;
          rem_d   = '0;
        end else begin
          y_d     = stuck_q;
          fault_d = 1'b1;
          rem_d   = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr_i) begin
      cnt_d = '0;
    end else if (fault_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      stuck_q <= 1'b0;
      y_q     <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      stuck_q <= stuck_d;
      y_q     <= y_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign io.y_o      = y_q;
  assign io.fault_o  = fault_q;
  assign fault_cnt_o = cnt_q;

endmodule

// File: tb/tb_fault_injector.sv
// tb/tb_fault_injector.sv - directed vector bench for fault_injector
module tb_fault_injector;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] thresh = 16'h0000;
  logic [3:0]  burst = 4'd0;
  logic        clr = 1'b0;
  logic        x = 1'b0;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  int n_cmp = 0;
  int n_bad = 0;

  fault_injector_if bus ();
  fault_injector_if bus4 ();
  assign bus.x_i  = x;
  assign bus4.x_i = x;

  fault_injector #(.SEED(16'hACE1), .BURST_W(4), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .thresh_i(thresh),
    .burst_len_i(burst), .clr_i(clr), .io(bus), .fault_cnt_o(cnt)
  );

  fault_injector #(.SEED(16'hACE1), .BURST_W(4), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .thresh_i(thresh),
    .burst_len_i(burst), .clr_i(clr), .io(bus4), .fault_cnt_o(cnt4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [1:0]  mode;
    logic [15:0] thresh;
    logic [3:0]  burst;
    logic        clr;
    logic        x;
    logic        ey;
    logic        ef;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vec [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_out(input string name, input logic ey, input logic ef, input logic [15:0] ec);
    check({name, ".y"}, 32'(bus.y_o), 32'(ey));
    check({name, ".fault"}, 32'(bus.fault_o), 32'(ef));
    check({name, ".cnt"}, 32'(cnt), 32'(ec));
  endtask

  initial begin
    int nf;
    // LFSR walk from ACE1: E270 7138 389C 1C4E 0E27 B313 ED89 C2C4
    vec[0]  = '{1'b0, 2'd1, 16'hFFFF, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    vec[1]  = '{1'b0, 2'd1, 16'hFFFF, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vec[2]  = '{1'b1, 2'd1, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    vec[3]  = '{1'b1, 2'd1, 16'hFFFF, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1};
    vec[4]  = '{1'b1, 2'd0, 16'hFFFF, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
    vec[5]  = '{1'b1, 2'd1, 16'h389C, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    vec[6]  = '{1'b1, 2'd1, 16'h1C4F, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2};
    vec[7]  = '{1'b1, 2'd1, 16'hFFFF, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd0};
    vec[8]  = '{1'b1, 2'd2, 16'hFFFF, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1};
    vec[9]  = '{1'b1, 2'd3, 16'hFFFF, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2};
    vec[10] = '{1'b1, 2'd3, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};

    @(negedge clk);
    do_reset();
    check_out("reset", 1'b0, 1'b0, 16'd0);

    // Disabled: LFSR frozen, y follows x one cycle later
    en = 1'b0; mode = 2'd1; thresh = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      x = i[0];
      @(negedge clk);
      check_out("disabled", i[0], 1'b0, 16'd0);
      check("disabled.lfsr", 32'(dut.lfsr), 32'h0000ACE1);
    end

    // Zero threshold never fires
    en = 1'b1; thresh = 16'h0000; nf = 0;
    for (int i = 0; i < 1000; i++) begin
      x = ~x;
      @(negedge clk);
      if (bus.fault_o) nf++;
    end
    check("thresh0.faults", 32'(nf), 32'd0);
    check("thresh0.cnt", 32'(cnt), 32'd0);

    // Table of single-cycle vectors from a fresh reset
    do_reset();
    for (int i = 0; i < 11; i++) begin
      en = vec[i].en; mode = vec[i].mode; thresh = vec[i].thresh;
      burst = vec[i].burst; clr = vec[i].clr; x = vec[i].x;
      @(negedge clk);
      check_out($sformatf("vec%0d", i), vec[i].ey, vec[i].ef, vec[i].ecnt);
    end
    clr = 1'b0;

    // STUCK1 burst of 4; config changes mid-burst must be ignored
    do_reset();
    en = 1'b1; mode = 2'd3; burst = 4'd4; thresh = 16'hFFFF; x = 1'b0;
    @(negedge clk);
    check_out("burst4.c0", 1'b1, 1'b1, 16'd1);
    mode = 2'd0; thresh = 16'h0000; burst = 4'd0;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check_out($sformatf("burst4.c%0d", i), 1'b1, 1'b1, 16'(i + 1));
    end
    @(negedge clk);
    check_out("burst4.end", 1'b0, 1'b0, 16'd4);

    // en_i dropped in second burst cycle aborts at once
    do_reset();
    en = 1'b1; mode = 2'd2; burst = 4'd4; thresh = 16'hFFFF; x = 1'b1;
    @(negedge clk);
    check_out("abort.c0", 1'b0, 1'b1, 16'd1);
    en = 1'b0;
    @(negedge clk);
    check_out("abort.c1", 1'b1, 1'b0, 16'd1);
    @(negedge clk);
    check_out("abort.c2", 1'b1, 1'b0, 16'd1);

    // Back-to-back bursts with no gap; retrigger takes the new mode
    do_reset();
    en = 1'b1; mode = 2'd3; burst = 4'd2; thresh = 16'hFFFF; x = 1'b0;
    @(negedge clk);
    check_out("b2b.c0", 1'b1, 1'b1, 16'd1);
    mode = 2'd2;
    @(negedge clk);
    check_out("b2b.c1", 1'b1, 1'b1, 16'd2);
    @(negedge clk);
    check_out("b2b.c2", 1'b0, 1'b1, 16'd3);
    thresh = 16'h0000;
    @(negedge clk);
    check_out("b2b.c3", 1'b0, 1'b1, 16'd4);
    x = 1'b1;
    @(negedge clk);
    check_out("b2b.c4", 1'b1, 1'b0, 16'd4);

    // Reset in the middle of a burst
    do_reset();
    en = 1'b1; mode = 2'd3; burst = 4'd8; thresh = 16'hFFFF; x = 1'b0;
    @(negedge clk);
    thresh = 16'h0000;
    @(negedge clk);
    check_out("midrst.pre", 1'b1, 1'b1, 16'd2);
    #2 rst = 1'b1;
    #1 check_out("midrst.now", 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    check("midrst.lfsr", 32'(dut.lfsr), 32'h0000ACE1);
    mode = 2'd1; thresh = 16'hACE2; x = 1'b1;
    @(negedge clk);
    check_out("midrst.first", 1'b0, 1'b1, 16'd1);

    // Saturation on the 4-bit counter instance: 20 forced cycles
    do_reset();
    en = 1'b1; mode = 2'd1; thresh = 16'hFFFF; x = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("sat.fault%0d", i), 32'(bus4.fault_o), 32'd1);
      check($sformatf("sat.cnt4_%0d", i), 32'(cnt4), (i < 15) ? 32'(i + 1) : 32'd15);
    end
    check("sat.cnt16", 32'(cnt), 32'd20);

    // Clear together with a fault
    clr = 1'b1;
    @(negedge clk);
    check("clr.fault", 32'(bus.fault_o), 32'd1);
    check("clr.cnt", 32'(cnt), 32'd0);
    check("clr.cnt4", 32'(cnt4), 32'd0);
    clr = 1'b0;
    @(negedge clk);
    check("clr.after", 32'(cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fault_injector.md
# fault_injector

- Configurable single-bit fault source placed directly upstream of the gate-under-test stage.
- Takes a clean logic stream and emits it one cycle later, with faults injected pseudo-randomly: transient bit flips or stuck-at bursts.
- Used to exercise the reliable-logic correction stages with a controlled, reproducible error rate.
- Counts every injected cycle so benches can compare observed errors against injected ones.

## Interface

Parameters:
- SEED, 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.
- BURST_W, 4: width of the burst length input.
- CNT_W, 16: width of the fault counter.

Ports:
- clk_i  input  1  clock; all state updates on its rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- en_i  input  1  injector enable; LFSR frozen when low.
- mode_i  input  2  00 OFF, 01 FLIP, 10 STUCK0, 11 STUCK1.
- thresh_i  input  16  trigger fires when lfsr < thresh_i.
- burst_len_i  input  BURST_W  stuck burst length in cycles; 0 is treated as 1.
- clr_i  input  1  synchronous clear of fault_cnt_o.
- x_i  input  1  clean data in.
- y_o  output  1  data out, possibly faulted (registered).
- fault_o  output  1  high in the cycle y_o carries an injected value (registered).
- fault_cnt_o  output  CNT_W  saturating count of injected cycles.

## Operation

- LFSR:
  - 16-bit Galois, taps 16'hB400, right shift: next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
  - Advances every cycle with en_i=1; holds when en_i=0. Never reaches 0.
- trigger = en_i && mode_i!=OFF && (lfsr < thresh_i), evaluated on the current LFSR value.
  - thresh_i=0: never fires.
  - thresh_i=16'hFFFF: fires on every LFSR value except 16'hFFFF.
- FSM states:
  - IDLE:
    - No trigger: y <= x_i, fault <= 0.
    - Trigger in FLIP: y <= ~x_i, fault <= 1, stay in IDLE.
    - Trigger in STUCK0/1: y <= mode_i[0], fault <= 1; latch stuck value; load rem = max(burst_len_i,1) - 1; go to BURST if rem != 0.
  - BURST:
    - y <= latched stuck value, fault <= 1, rem decrements; return to IDLE when rem reaches 0.
    - mode_i, thresh_i and burst_len_i are ignored while in BURST.
    - No new trigger is evaluated until back in IDLE. The LFSR still advances.
    - en_i=0 in BURST: abort to IDLE in that same cycle; y <= x_i, fault <= 0.
- A forced cycle counts as a fault even if the forced value equals x_i.
- Counter:
  - fault_cnt_o increments on each cycle fault is set, saturating at 2^CNT_W-1.
  - clr_i zeroes it; clr_i wins over a simultaneous increment.

## Timing

- Latency is 1 cycle: y_o/fault_o at edge n+1 reflect x_i, LFSR and state at edge n.
- fault_cnt_o updates on the same edge as fault_o (it counts the fault being registered).
- Reset values:
  - y_o=0, fault_o=0, fault_cnt_o=0
  - lfsr=SEED, state=IDLE, rem=0, stuck value 0.
- Reset mid-burst aborts immediately. The first post-reset cycle is IDLE with lfsr=SEED.
- After a burst ends, IDLE may re-trigger on the very next cycle; there are no gap cycles.

## Structure

- Package fault_pkg holds:
  - enum fault_mode_e {OFF, FLIP, STUCK0, STUCK1}
  - enum inj_state_e {IDLE, BURST}
  - localparam LFSR_TAPS = 16'hB400
- Sub-module lfsr16 (clk_i, rst_i, en_i, q_o, SEED parameter) contains the generator. The top holds the FSM, output register and counter.

## Test plan

- Reset, en_i=0 for 10 cycles → lfsr stays 16'hACE1; y_o tracks x_i with 1-cycle delay; fault_o=0; fault_cnt_o=0.
- en_i=1, mode FLIP, thresh 0, x_i toggling for 1000 cycles → no faults; fault_cnt_o=0.
- en_i=1, mode FLIP, thresh 16'hFFFF, x_i=1 for 1 cycle:
  - first LFSR value is 16'hACE1, next is 16'hE270.
  - Next edge y_o=0, fault_o=1, fault_cnt_o=1.
- Mode STUCK1, burst_len 4, x_i=0, thresh 16'hFFFF for 1 cycle then 0:
  - y_o=1 and fault_o=1 for exactly 4 cycles, then y_o=0 and fault_o=0.
  - fault_cnt_o=4.
- Same burst with en_i dropped in its 2nd cycle → the burst aborts that cycle; fault_cnt_o=1.
- Reset mid-burst → outputs are 0 immediately.
- CNT_W=4, 20 forced cycles → fault_cnt_o saturates at 15.
- clr_i asserted together with a fault → fault_cnt_o=0.
